// File: rtl/seg7_scan_reader_if.sv
// Frame output bus of seg7_scan_reader: decoded digits, error flags and the valid/ready pair.
// With SEG7_SCAN_DP_EN defined, the bus also carries the per-digit decimal-point flags.
interface seg7_scan_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_out;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    frame_valid;
  logic                    frame_ready;
`ifdef SEG7_SCAN_DP_EN
  logic [NUM_DIGITS-1:0]   dp_out;
`endif

  // Handshake: the producer raises frame_valid with bcd_out/digit_err stable and
  // holds them unchanged until a cycle where frame_ready=1; that cycle is the transfer.
  modport master (
`ifdef SEG7_SCAN_DP_EN
    output dp_out,
`endif
    output bcd_out,
    output digit_err,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
`ifdef SEG7_SCAN_DP_EN
    input  dp_out,
`endif
    input  bcd_out,
    input  digit_err,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// Reconstructs BCD digits from a multiplexed active-low 7-segment bus, one frame per scan.
// Optional decimal-point capture is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [NUM_DIGITS-1:0] an_n,
`ifdef SEG7_SCAN_DP_EN
  input  logic                  dp_n,
`endif
  output logic                  overrun,
  seg7_scan_reader_if.master    frame
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  // Returns {err, nibble}; blank reads as F, anything unrecognised as E with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = 5'h00;
      7'b1001111: r = 5'h01;
      7'b0010010: r = 5'h02;
      7'b0000110: r = 5'h03;
      7'b1001100: r = 5'h04;
      7'b0100100: r = 5'h05;
      7'b0100000: r = 5'h06;
      7'b0001111: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0000100: r = 5'h09;
      7'b1111111: r = 5'h0F;
      default:    r = 5'h1E;
    endcase
    return r;
  endfunction

  logic [6:0]              seg_s1, seg_s2, seg_p;
  logic [NUM_DIGITS-1:0]   an_s1, an_s2, an_p;
`ifdef SEG7_SCAN_DP_EN
  logic                    dp_s1, dp_s2, dp_p;
  logic [NUM_DIGITS-1:0]   shadow_dp;
`endif

  logic [NUM_DIGITS-1:0]   an_act;
  logic                    an_onehot;
  logic                    same;
  logic                    capture;
  logic [4:0]              dec;
  logic                    mask_full;
  logic                    load_ok;

  logic [7:0]              cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_err;

  // Two-flop synchronizers plus a copy of the previous synchronized sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
      an_p   <= '1;
`ifdef SEG7_SCAN_DP_EN
      dp_s1  <= 1'b1;
      dp_s2  <= 1'b1;
      dp_p   <= 1'b1;
`endif
    end else begin
      seg_s1 <= seg_n;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
      an_s1  <= an_n;
      an_s2  <= an_s1;
      an_p   <= an_s2;
`ifdef SEG7_SCAN_DP_EN
      dp_s1  <= dp_n;
      dp_s2  <= dp_s1;
      dp_p   <= dp_s2;
`endif
    end
  end

  always_comb begin
    an_act    = ~an_s2;
    an_onehot = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
    same      = (seg_s2 == seg_p) && (an_s2 == an_p);
`ifdef SEG7_SCAN_DP_EN
    same      = same && (dp_s2 == dp_p);
`endif
    // Fires only on the step into saturation, so a dwell yields at most one capture.
    capture   = an_onehot && same && (cnt == CNT_MAX - 8'd1);
    dec       = decode(seg_s2);
    mask_full = &mask;
    load_ok   = !frame.frame_valid || frame.frame_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!an_onehot || !same) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Shadow registers collect the current frame; an already-captured digit is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask       <= '0;
      shadow_bcd <= '0;
      shadow_err <= '0;
`ifdef SEG7_SCAN_DP_EN
      shadow_dp  <= '0;
`endif
    end else if (mask_full) begin
      mask <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && an_act[i] && !mask[i]) begin
          shadow_bcd[4*i +: 4] <= dec[3:0];
          shadow_err[i]        <= dec[4];
          mask[i]              <= 1'b1;
`ifdef SEG7_SCAN_DP_EN
          shadow_dp[i]         <= !dp_s2;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame.bcd_out     <= '0;
      frame.digit_err   <= '0;
      frame.frame_valid <= 1'b0;
      overrun           <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      frame.dp_out      <= '0;
`endif
    end else if (mask_full) begin
      if (load_ok) begin
        frame.bcd_out     <= shadow_bcd;
        frame.digit_err   <= shadow_err;
        frame.frame_valid <= 1'b1;
`ifdef SEG7_SCAN_DP_EN
        frame.dp_out      <= shadow_dp;
`endif
      end else begin
        overrun <= 1'b1;
      end
    end else if (frame.frame_valid && frame.frame_ready) begin
      frame.frame_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: table of full scans plus hand sequences for
// short dwells, shared anodes, first-wins, backpressure/overrun and mid-frame reset.
module tb_seg7_scan_reader;

  localparam int ND = 4;
  localparam int W  = 5 * ND;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    seg_n = '1;
  logic [ND-1:0] an_n = '1;
  logic          overrun;
`ifdef SEG7_SCAN_DP_EN
  logic          dp_n = 1'b1;
`endif

  seg7_scan_reader_if #(.NUM_DIGITS(ND)) frame ();

  seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_n   (seg_n),
    .an_n    (an_n),
`ifdef SEG7_SCAN_DP_EN
    .dp_n    (dp_n),
`endif
    .overrun (overrun),
    .frame   (frame.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_data [64];
  int          got_n = 0;
  int          rd_n = 0;

  // Records every completed transfer ({digit_err, bcd_out}) for the main thread to compare.
  always @(negedge clk) begin
    if (!rst && frame.frame_valid && frame.frame_ready && got_n < 64) begin
      got_data[got_n] = {frame.digit_err, frame.bcd_out};
      got_n = got_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    logic [W-1:0] e;
    while (rd_n < got_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected frame: got %h expected none", name, got_data[rd_n]);
      end else begin
        e = exp_q.pop_front();
        if (got_data[rd_n] !== e) begin
          errors++;
          $display("FAIL %s frame: got %h expected %h", name, got_data[rd_n], e);
        end
      end
      rd_n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing frame: got none expected %h", name, exp_q[0]);
      exp_q.delete();
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] pack4(input logic [6:0] p0, input logic [6:0] p1,
                                        input logic [6:0] p2, input logic [6:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic idle(input int n);
    an_n  = '1;
    seg_n = '1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int dwell);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [27:0] segs, input int dwell);
    for (int i = 0; i < ND; i++) show(i, segs[7*i +: 7], dwell);
    an_n  = '1;
    seg_n = '1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [27:0] segs;
    int          dwell;
    bit          want;
    logic [15:0] bcd;
    logic [3:0]  err;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{pack4(pat(1), pat(2), pat(3), pat(4)), 8, 1'b1, 16'h4321, 4'b0000};
    vt[1] = '{pack4(pat(0), pat(9), 7'b1111110, 7'b1111111), 8, 1'b1, 16'hFE90, 4'b0100};
    vt[2] = '{pack4(pat(5), pat(6), pat(7), pat(8)), 5, 1'b1, 16'h8765, 4'b0000};
    vt[3] = '{pack4(pat(1), pat(2), pat(3), pat(4)), 3, 1'b0, 16'h0000, 4'b0000};
    vt[4] = '{pack4(pat(0), pat(8), pat(9), pat(7)), 4, 1'b1, 16'h7980, 4'b0000};
    vt[5] = '{pack4(pat(2), pat(3), 7'b1111111, 7'b0110000), 6, 1'b1, 16'hEF32, 4'b1000};

    // Reset state
    frame.frame_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset frame_valid", 32'(frame.frame_valid), 32'd0);
    chk("reset bcd_out", 32'(frame.bcd_out), 32'd0);
    chk("reset digit_err", 32'(frame.digit_err), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(2);

    // Table of full scans with the consumer always ready
    for (int i = 0; i < 6; i++) begin
      if (vt[i].want) exp_q.push_back({vt[i].err, vt[i].bcd});
      scan(vt[i].segs, vt[i].dwell);
      idle(10);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d valid_low", i), 32'(frame.frame_valid), 32'd0);
      chk($sformatf("vec%0d overrun", i), 32'(overrun), 32'd0);
    end

    // Two anodes low must not capture; the following scan supplies every digit
    an_n  = 4'b1100;
    seg_n = pat(5);
    repeat (10) @(posedge clk);
    #1;
    idle(3);
    exp_q.push_back({4'b0000, 16'h4321});
    scan(pack4(pat(1), pat(2), pat(3), pat(4)), 8);
    idle(10);
    drain("two_anodes");

    // First dwell of a digit wins within a frame
    show(0, pat(1), 8);
    show(0, pat(9), 8);
    show(1, pat(2), 8);
    show(2, pat(3), 8);
    show(3, pat(4), 8);
    exp_q.push_back({4'b0000, 16'h4321});
    idle(10);
    drain("first_wins");

    // Backpressure: first frame held, second dropped, overrun set
    frame.frame_ready = 1'b0;
    scan(pack4(pat(1), pat(2), pat(3), pat(4)), 6);
    idle(8);
    chk("bp first valid", 32'(frame.frame_valid), 32'd1);
    chk("bp first bcd", 32'(frame.bcd_out), 32'h4321);
    chk("bp first overrun", 32'(overrun), 32'd0);
    scan(pack4(pat(5), pat(6), pat(7), pat(8)), 6);
    idle(8);
    chk("bp held bcd", 32'(frame.bcd_out), 32'h4321);
    chk("bp held err", 32'(frame.digit_err), 32'd0);
    chk("bp held valid", 32'(frame.frame_valid), 32'd1);
    chk("bp overrun", 32'(overrun), 32'd1);
    exp_q.push_back({4'b0000, 16'h4321});
    frame.frame_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp valid falls", 32'(frame.frame_valid), 32'd0);
    idle(4);
    drain("backpressure");
    chk("overrun sticky", 32'(overrun), 32'd1);

    // Reset after two digits: the partial frame is discarded
    show(0, pat(1), 8);
    show(1, pat(2), 8);
    idle(3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst overrun", 32'(overrun), 32'd0);
    chk("midrst valid", 32'(frame.frame_valid), 32'd0);
    exp_q.push_back({4'b0000, 16'h8765});
    scan(pack4(pat(5), pat(6), pat(7), pat(8)), 8);
    idle(10);
    drain("mid_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
